// File: rtl/sram_dual_port_arbiter_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
package sram_dual_port_arbiter_pkg;

  localparam int unsigned DefAddrW = 18;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned WaitW    = 4;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic logic [WaitW-1:0] wait_load(input logic        we,
                                                 input int unsigned rd_wait,
                                                 input int unsigned wr_wait);
    return we ? WaitW'(wr_wait) : WaitW'(rd_wait);
  endfunction

endpackage

// File: rtl/sram_dual_port_arbiter_if.sv
// Requester-side bus for one arbiter port: request fields in, ack and read data out.
interface sram_dual_port_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        be_n;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output req, we, addr, wdata, be_n, input ack, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, be_n, output ack, rdata, rvalid);
endinterface

// File: rtl/sram_dual_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only advances when the owner accepts a grant.
module sram_dual_port_arbiter_rr_arb2
  import sram_dual_port_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  logic last_grant_q;

  assign grant_valid_o = |req_i;

  always_comb begin
    grant_idx_o = Port0;
    case (req_i)
      2'b01:   grant_idx_o = Port0;
      2'b10:   grant_idx_o = Port1;
      2'b11:   grant_idx_o = ~last_grant_q;
      default: grant_idx_o = Port0;
    endcase
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= Port1;
    end else if (advance_i && grant_valid_o) begin
      last_grant_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/sram_dual_port_arbiter.sv
// Shares one 256K x 16 asynchronous SRAM between two requesters with round-robin grants
// and timed read/write cycles; every SRAM pin is driven from a register.
module sram_dual_port_arbiter
  import sram_dual_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  sram_dual_port_arbiter_if.slave p0_if,
  sram_dual_port_arbiter_if.slave p1_if,
  output logic [ADDR_W-1:0]       SRAM_ADDR,
  inout  wire  [DATA_W-1:0]       SRAM_DQ,
  output logic                    SRAM_CE_N,
  output logic                    SRAM_OE_N,
  output logic                    SRAM_WE_N,
  output logic                    SRAM_UB_N,
  output logic                    SRAM_LB_N,
  output logic                    dq_oe_o
);

  state_e            state_q;
  logic [WaitW-1:0]  wcnt_q;
  logic              we_q;
  logic              gnt_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic [1:0]        ack_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic [1:0]        req;
  logic              grant_valid;
  logic              grant_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        win_be_n;

  assign req = {p1_if.req, p0_if.req};

  sram_dual_port_arbiter_rr_arb2 u_arb (
    .clk_i        (iCLK),
    .rst_ni       (iRST_N),
    .req_i        (req),
    .advance_i    (state_q == StIdle),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  always_comb begin
    win_we    = p0_if.we;
    win_addr  = p0_if.addr;
    win_wdata = p0_if.wdata;
    win_be_n  = p0_if.be_n;
    if (grant_idx == Port1) begin
      win_we    = p1_if.we;
      win_addr  = p1_if.addr;
      win_wdata = p1_if.wdata;
      win_be_n  = p1_if.be_n;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      we_q      <= 1'b0;
      gnt_q     <= Port0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_q   <= StAccess;
            gnt_q     <= grant_idx;
            we_q      <= win_we;
            wcnt_q    <= wait_load(win_we, RD_WAIT, WR_WAIT);
            dq_out_q  <= win_wdata;
            dq_oe_q   <= win_we;
            ack_q     <= (grant_idx == Port1) ? 2'b10 : 2'b01;
            SRAM_ADDR <= win_addr;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= win_we;
            SRAM_WE_N <= ~win_we;
            SRAM_UB_N <= win_be_n[1];
            SRAM_LB_N <= win_be_n[0];
          end
        end
        StAccess: begin
          if (wcnt_q == '0) begin
            state_q   <= StDone;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            // Read data is captured on the same edge that ends the access window.
            if (!we_q) begin
              if (gnt_q == Port1) begin
                rdata1_q    <= SRAM_DQ;
                rvalid_q[1] <= 1'b1;
              end else begin
                rdata0_q    <= SRAM_DQ;
                rvalid_q[0] <= 1'b1;
              end
            end
          end else begin
            wcnt_q <= wcnt_q - WaitW'(1);
          end
        end
        StDone: begin
          state_q   <= StIdle;
          dq_oe_q   <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign SRAM_DQ = dq_oe_q ? dq_out_q : 'z;
  assign dq_oe_o = dq_oe_q;

  assign p0_if.ack    = ack_q[0];
  assign p1_if.ack    = ack_q[1];
  assign p0_if.rvalid = rvalid_q[0];
  assign p1_if.rvalid = rvalid_q[1];
  assign p0_if.rdata  = rdata0_q;
  assign p1_if.rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// Bench for sram_dual_port_arbiter: directed timing scenarios plus randomized traffic
// checked against a word-level memory model and round-robin grant rule.
module tb_sram_dual_port_arbiter;
  import sram_dual_port_arbiter_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int RdWait = 1;
  localparam int WrWait = 1;
  localparam int MemWords = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_bus ();
  sram_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_bus ();

  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, dq_oe;

  sram_dual_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RdWait), .WR_WAIT(WrWait)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .p0_if    (p0_bus),
    .p1_if    (p1_bus),
    .SRAM_ADDR(sram_addr),
    .SRAM_DQ  (sram_dq),
    .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n),
    .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n),
    .dq_oe_o  (dq_oe)
  );

  // Asynchronous SRAM device model: drives DQ during a read, writes enabled lanes mid-cycle.
  logic [DW-1:0] sram_mem [MemWords];
  logic [DW-1:0] mem_rd;
  assign mem_rd  = sram_mem[sram_addr];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem_rd : 'z;

  initial begin
    for (int i = 0; i < MemWords; i++) sram_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n) begin
        if (!sram_lb_n) sram_mem[sram_addr][7:0] = sram_dq[7:0];
        if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [MemWords];
  logic          model_last;
  int            checks = 0;
  int            errors = 0;

  wire [1:0] ack_w    = {p1_bus.ack, p0_bus.ack};
  wire [1:0] rvalid_w = {p1_bus.rvalid, p0_bus.rvalid};

  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p == 0) ? p0_bus.rdata : p1_bus.rdata;
  endfunction

  function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [1:0] be_n);
    if (!be_n[0]) ref_mem[a][7:0] = d[7:0];
    if (!be_n[1]) ref_mem[a][15:8] = d[15:8];
  endfunction

  task automatic drive(input int p, input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] be_n);
    if (p == 0) begin
      p0_bus.req = req; p0_bus.we = we; p0_bus.addr = a; p0_bus.wdata = d; p0_bus.be_n = be_n;
    end else begin
      p1_bus.req = req; p1_bus.we = we; p1_bus.addr = a; p1_bus.wdata = d; p1_bus.be_n = be_n;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) p0_bus.req = 1'b0;
    else p1_bus.req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, 2'b11);
    drive(1, 1'b0, 1'b0, '0, '0, 2'b11);
    repeat (3) @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      errors++;
      $display("FAIL rst_strobes got %b exp 11111",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    checks++;
    if (dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe got %b exp 0", dq_oe); end
    checks++;
    if (sram_addr !== '0) begin errors++; $display("FAIL rst_addr got %h exp 0", sram_addr); end
    checks++;
    if ({ack_w, rvalid_w} !== 4'b0) begin
      errors++; $display("FAIL rst_ack_rvalid got %b exp 0000", {ack_w, rvalid_w});
    end
    checks++;
    if ({p1_bus.rdata, p0_bus.rdata} !== '0) begin
      errors++; $display("FAIL rst_rdata got %h exp 0", {p1_bus.rdata, p0_bus.rdata});
    end
    model_last = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_timing();
    logic exp_we_n, exp_drv;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 18'h00010, 16'hBEEF, 2'b00);
    for (int k = 1; k <= WrWait + 3; k++) begin
      @(negedge clk);
      exp_we_n = !(k <= WrWait + 1);
      exp_drv  = (k <= WrWait + 2);
      checks++;
      if (ack_w !== ((k == 1) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL wr_ack k=%0d got %b", k, ack_w);
      end
      checks++;
      if (sram_we_n !== exp_we_n) begin
        errors++; $display("FAIL wr_we_n k=%0d got %b exp %b", k, sram_we_n, exp_we_n);
      end
      checks++;
      if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL wr_oe_n k=%0d got 0 exp 1", k); end
      checks++;
      if (dq_oe !== exp_drv || sram_ce_n !== !exp_drv) begin
        errors++;
        $display("FAIL wr_dq_ce k=%0d got oe=%b ce_n=%b exp oe=%b", k, dq_oe, sram_ce_n, exp_drv);
      end
      if (exp_drv) begin
        checks++;
        if (sram_dq !== 16'hBEEF || sram_addr !== 18'h00010) begin
          errors++;
          $display("FAIL wr_bus k=%0d got dq=%h a=%h exp BEEF/00010", k, sram_dq, sram_addr);
        end
      end
      if (k == 1) begin
        drop(0);
        model_last = 1'b0;
        ref_write(18'h00010, 16'hBEEF, 2'b00);
      end
    end
  endtask

  task automatic test_read_timing(input int p, input logic [AW-1:0] a);
    logic exp_rv;
    @(negedge clk);
    drive(p, 1'b1, 1'b0, a, 16'h0000, 2'b00);
    for (int k = 1; k <= RdWait + 3; k++) begin
      @(negedge clk);
      exp_rv = (k == RdWait + 2);
      checks++;
      if (ack_w !== ((k == 1) ? (2'b01 << p) : 2'b00)) begin
        errors++; $display("FAIL rd_ack p%0d k=%0d got %b", p, k, ack_w);
      end
      checks++;
      if (sram_oe_n !== !(k <= RdWait + 1) || sram_we_n !== 1'b1 || dq_oe !== 1'b0) begin
        errors++;
        $display("FAIL rd_strobe k=%0d got oe_n=%b we_n=%b dq_oe=%b", k, sram_oe_n, sram_we_n,
                 dq_oe);
      end
      checks++;
      if (rvalid_w !== (exp_rv ? (2'b01 << p) : 2'b00)) begin
        errors++; $display("FAIL rd_rvalid p%0d k=%0d got %b", p, k, rvalid_w);
      end
      if (exp_rv) begin
        checks++;
        if (rdata_of(p) !== ref_mem[a]) begin
          errors++; $display("FAIL rd_data p%0d got %h exp %h", p, rdata_of(p), ref_mem[a]);
        end
      end
      if (k == 1) begin drop(p); model_last = 1'(p); end
    end
  endtask

  task automatic test_alternate();
    int n = 0, cyc = 0, last_cyc = 0;
    logic exp_p;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 18'h00010, '0, 2'b00);
    drive(1, 1'b1, 1'b0, 18'h00020, '0, 2'b00);
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack_w != 2'b00) begin
        exp_p = !model_last;
        checks++;
        if (ack_w !== (2'b01 << exp_p)) begin
          errors++; $display("FAIL alt_grant n=%0d got %b exp port %0d", n, ack_w, exp_p);
        end
        checks++;
        if (cyc - last_cyc !== ((n == 0) ? 1 : RdWait + 3)) begin
          errors++; $display("FAIL alt_spacing n=%0d got %0d", n, cyc - last_cyc);
        end
        model_last = exp_p;
        last_cyc = cyc;
        n++;
        if (n == 6) begin drop(0); drop(1); end
      end
    end
    checks++;
    if (n !== 6) begin errors++; $display("FAIL alt_timeout got %0d acks exp 6", n); drop(0); drop(1); end
    repeat (RdWait + 3) @(negedge clk);
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 18'h00010, 16'h12AB, 2'b10);
    for (int k = 1; k <= WrWait + 3; k++) begin
      @(negedge clk);
      if (k <= WrWait + 1) begin
        checks++;
        if ({sram_ub_n, sram_lb_n} !== 2'b10) begin
          errors++; $display("FAIL bw_lanes k=%0d got %b exp 10", k, {sram_ub_n, sram_lb_n});
        end
      end
      if (k == 1) begin drop(0); model_last = 1'b0; ref_write(18'h00010, 16'h12AB, 2'b10); end
    end
    test_read_timing(1, 18'h00010);
    checks++;
    if (p1_bus.rdata !== 16'hBEAB) begin
      errors++; $display("FAIL bw_merge got %h exp BEAB", p1_bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 18'h00020, '0, 2'b00);
    @(negedge clk);
    checks++;
    if (ack_w !== 2'b01) begin errors++; $display("FAIL rm_ack got %b exp 01", ack_w); end
    drop(0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dq_oe !== 1'b0 || sram_ce_n !== 1'b1 || p0_bus.rdata !== '0) begin
      errors++;
      $display("FAIL rm_state got dq_oe=%b ce_n=%b rdata0=%h", dq_oe, sram_ce_n, p0_bus.rdata);
    end
    rst_n = 1'b1;
    model_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rvalid_w !== 2'b00) begin errors++; $display("FAIL rm_rvalid k=%0d got %b", k, rvalid_w); end
      @(negedge clk);
    end
    drive(0, 1'b1, 1'b0, 18'h00010, '0, 2'b00);
    drive(1, 1'b1, 1'b0, 18'h00010, '0, 2'b00);
    while (ack_w == 2'b00 && budget < 20) begin @(negedge clk); budget++; end
    checks++;
    if (ack_w !== 2'b01) begin errors++; $display("FAIL rm_first_grant got %b exp 01", ack_w); end
    model_last = 1'b0;
    drop(0); drop(1);
    repeat (RdWait + 3) @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [1:0]    pend, rdp;
    logic          t_we   [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_wd   [2];
    logic [1:0]    t_be   [2];
    logic [DW-1:0] exp_rd [2];
    logic          exp_p;
    int            budget;
    for (int it = 0; it < n; it++) begin
      @(negedge clk);
      pend = 2'($urandom_range(1, 3));
      rdp  = 2'b00;
      for (int p = 0; p < 2; p++) begin
        t_we[p]   = 1'($urandom);
        t_addr[p] = 18'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? 18'h3FFE0 : '0);
        t_wd[p]   = 16'($urandom);
        t_be[p]   = t_we[p] ? 2'($urandom) : 2'b00;
        drive(p, pend[p], t_we[p], t_addr[p], t_wd[p], t_be[p]);
      end
      budget = 0;
      while ((pend != 2'b00 || rdp != 2'b00) && budget < 40) begin
        @(negedge clk);
        budget++;
        for (int p = 0; p < 2; p++) begin
          if (ack_w[p]) begin
            exp_p = (pend == 2'b11) ? !model_last : pend[1];
            checks++;
            if (!pend[p] || 1'(p) !== exp_p) begin
              errors++; $display("FAIL rnd_grant it=%0d got port %0d exp port %0d", it, p, exp_p);
            end
            model_last = 1'(p);
            if (t_we[p]) ref_write(t_addr[p], t_wd[p], t_be[p]);
            else begin exp_rd[p] = ref_mem[t_addr[p]]; rdp[p] = 1'b1; end
            pend[p] = 1'b0;
            drop(p);
          end
          if (rvalid_w[p]) begin
            checks++;
            if (!rdp[p] || rdata_of(p) !== exp_rd[p]) begin
              errors++;
              $display("FAIL rnd_rdata it=%0d p%0d got %h exp %h pending=%b", it, p, rdata_of(p),
                       exp_rd[p], rdp[p]);
            end
            rdp[p] = 1'b0;
          end
        end
      end
      checks++;
      if (budget >= 40) begin
        errors++; $display("FAIL rnd_timeout it=%0d got pend=%b rdp=%b exp 00", it, pend, rdp);
        drop(0); drop(1);
      end
    end
    repeat (RdWait + 3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < MemWords; i++) ref_mem[i] = '0;
    test_reset();
    test_write_timing();
    test_read_timing(1, 18'h00010);
    test_alternate();
    test_byte_write();
    test_reset_mid();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
